// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control slice: watchdog state encoding, wait-counter width, saturating increment.
// Pure declarations, no logic or latency of its own.
package pipe_ctrl_pkg;

    localparam int WAIT_CTR_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } hz_state_t;

    function automatic logic [WAIT_CTR_W-1:0] sat_inc(input logic [WAIT_CTR_W-1:0] val);
        sat_inc = (&val) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with an increment enable; holds at all-ones.
// Latency: count visible the cycle after the enabled edge. No backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_en && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control with memory-wait watchdog; perf counters under HAZARD_CTRL_PERF_EN.
// Latency: enables/flushes are combinational (zero cycles); state, watchdog and counters update on clk.
// Backpressure: mem_busy freezes every pipeline register; FAULT freezes them until reset.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
`endif
    output logic             mem_timeout
);

    hz_state_t             state_d, state_q;
    logic [WAIT_CTR_W-1:0] wait_ctr_d, wait_ctr_q;
    logic                  mem_timeout_d, mem_timeout_q;

    logic frozen;
    logic apply_flush;
    logic apply_bubble;
    logic busy_counted;

    assign frozen       = (state_q == FAULT) || mem_busy;
    assign apply_flush  = !frozen && branch_taken;
    assign apply_bubble = !frozen && !branch_taken && load_use;
    assign busy_counted = mem_busy && (state_q != FAULT);

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        if (frozen) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (apply_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (apply_bubble) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Watchdog: wait_ctr counts consecutive busy cycles; a busy cycle beyond MAX_WAIT traps.
    always_comb begin
        state_d       = state_q;
        wait_ctr_d    = wait_ctr_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = WAIT;
                    wait_ctr_d = WAIT_CTR_W'(1);
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_ctr_d = '0;
                end else if (wait_ctr_q == WAIT_CTR_W'(MAX_WAIT)) begin
                    state_d       = FAULT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_ctr_d = sat_inc(wait_ctr_q);
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_ctr_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_ctr_q    <= wait_ctr_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_CTRL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (apply_bubble),
        .cnt    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (apply_flush),
        .cnt    (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (busy_counted),
        .cnt    (wait_cnt)
    );
`endif

endmodule
